collector_stat_fifo: RTL

- Parametrised next-generation PE-side collector. Sinks packets from a router Local Port over the Req/Gnt/Full handshake.
- Each accepted packet gets an arrival timestamp and is buffered in a FIFO. A downstream consumer (monitor/PE model) drains the FIFO with valid/ready.
- Per-sender PacketID sequencing is checked. Packet and sequence-error statistics are kept.
- One instance per mesh node. The instance replaces the per-node fixed collectors.

---
 rtl/noc_pkt_pkg.sv | 37 +++
 rtl/collector_stat_fifo_if.sv | 37 +++
 rtl/sync_fifo_fwft.sv | 70 +++++++
 rtl/collector_stat_fifo.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet field layout, collector FSM encodings and sender-table indexing.
package noc_pkt_pkg;

  localparam int PID_MSB  = 24;
  localparam int PID_LSB  = 15;
  localparam int SID_MSB  = 14;
  localparam int SID_LSB  = 9;
  localparam int DATA_MSB = 8;
  localparam int PID_W    = PID_MSB - PID_LSB + 1;
  localparam int SID_W    = SID_MSB - SID_LSB + 1;

  typedef enum logic {
    WAIT_REQ = 1'b0,
    RECOVER  = 1'b1
  } state_e;

  // SenderID is {x[2:0], y[2:0]}; the table is laid out row-major on x.
  function automatic int unsigned sender_index(input logic [SID_W-1:0] sid,
                                               input int unsigned mesh_dim);
    int unsigned x;
    int unsigned y;
    x = 32'(sid[5:3]);
    y = 32'(sid[2:0]);
    return x * mesh_dim + y;
  endfunction

  function automatic logic sender_in_range(input logic [SID_W-1:0] sid,
                                           input int unsigned mesh_dim);
    int unsigned x;
    int unsigned y;
    x = 32'(sid[5:3]);
    y = 32'(sid[2:0]);
    return (x < mesh_dim) && (y < mesh_dim) &&
           (sender_index(sid, mesh_dim) < mesh_dim * mesh_dim);
  endfunction

endpackage

// File: rtl/collector_stat_fifo_if.sv
// Local Port, consumer and statistics signals of the collector, plus debug visibility.
// Handshakes: Local Port - a packet is taken on the edge where ReqUpStr=1 and the
// collector is idle and not full; GntUpStr pulses one cycle later. Consumer - the head
// is popped on every edge where OutValid && OutReady; OutData is stable while OutValid=1.
interface collector_stat_fifo_if #(
  parameter int packetwidth = 26,
  parameter int TS_W        = 16,
  parameter int CNT_W       = 16,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [packetwidth-1:0]      PacketIn;
  logic                        ReqUpStr;
  logic                        GntUpStr;
  logic                        UpStrFull;
  logic [TS_W+packetwidth-1:0] OutData;
  logic                        OutValid;
  logic                        OutReady;
  logic [CNT_W-1:0]            RxCount;
  logic [CNT_W-1:0]            SeqErrCount;
  logic [5:0]                  MyID;
  logic                        dbg_state;
  logic [CW-1:0]               dbg_count;

  modport slave (
    input  PacketIn, ReqUpStr, OutReady,
    output GntUpStr, UpStrFull, OutData, OutValid, RxCount, SeqErrCount, MyID,
           dbg_state, dbg_count
  );

  modport master (
    output PacketIn, ReqUpStr, OutReady,
    input  GntUpStr, UpStrFull, OutData, OutValid, RxCount, SeqErrCount, MyID,
           dbg_state, dbg_count
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head word is visible whenever not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the count alone decides which words are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/collector_stat_fifo.sv
// PE-side collector: accepts Local Port packets, timestamps and buffers them, and keeps
// per-sender PacketID sequence checking with saturating packet/error statistics.
module collector_stat_fifo
  import noc_pkt_pkg::*;
#(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter int         packetwidth = 26,
  parameter int         MESH_DIM    = 3,
  parameter int         DEPTH       = 4,
  parameter int         TS_W        = 16,
  parameter int         CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  collector_stat_fifo_if.slave bus
);
  localparam int NUM_SRC = MESH_DIM * MESH_DIM;
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int FW      = TS_W + packetwidth;
  localparam int CW      = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [TS_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [PID_W-1:0] last_pid_q [NUM_SRC];
  logic [PID_W-1:0] last_pid_d [NUM_SRC];
  logic [NUM_SRC-1:0] valid_q, valid_d;

  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    fifo_head;
  logic [FW-1:0]    push_data;

  logic [SID_W-1:0] sid;
  logic [PID_W-1:0] pid;
  logic             src_ok;
  logic [IDX_W-1:0] src_idx;
  logic [PID_W-1:0] expect_pid;
  logic             seq_err;

  // State register, grant flop and free-running timestamp counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= WAIT_REQ;
      gnt_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_REQ: if (accept) state_d = RECOVER;
      RECOVER:  state_d = WAIT_REQ;
      default:  state_d = WAIT_REQ;
    endcase
  end

  // Full is the registered flag, so a same-cycle pop never enables an accept.
  always_comb begin
    accept    = (state_q == WAIT_REQ) && bus.ReqUpStr && !fifo_full;
    gnt_d     = accept;
    cyc_d     = cyc_q + TS_W'(1);
    push_data = {cyc_q, bus.PacketIn};
    pop       = !fifo_empty && bus.OutReady;
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    sid        = bus.PacketIn[SID_MSB:SID_LSB];
    pid        = bus.PacketIn[PID_MSB:PID_LSB];
    src_ok     = sender_in_range(sid, MESH_DIM);
    src_idx    = IDX_W'(sender_index(sid, MESH_DIM));
    expect_pid = '0;
    rx_d       = rx_q;
    seq_d      = seq_q;
    valid_d    = valid_q;
    last_pid_d = last_pid_q;
    seq_err    = 1'b0;
    if (accept) begin
      if (rx_q != '1) rx_d = rx_q + CNT_W'(1);
      if (!src_ok) begin
        seq_err = 1'b1;
      end else begin
        // An out-of-order ID still becomes the new reference so one gap is one error.
        expect_pid = last_pid_q[src_idx] + PID_W'(1);
        if (valid_q[src_idx] && (pid != expect_pid)) seq_err = 1'b1;
        valid_d[src_idx]    = 1'b1;
        last_pid_d[src_idx] = pid;
      end
      if (seq_err && (seq_q != '1)) seq_d = seq_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_q    <= '0;
      seq_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) last_pid_q[i] <= '0;
    end else begin
      rx_q       <= rx_d;
      seq_q      <= seq_d;
      valid_q    <= valid_d;
      last_pid_q <= last_pid_d;
    end
  end

  assign bus.GntUpStr    = gnt_q;
  assign bus.UpStrFull   = fifo_full;
  assign bus.OutData     = fifo_head;
  assign bus.OutValid    = !fifo_empty;
  assign bus.RxCount     = rx_q;
  assign bus.SeqErrCount = seq_q;
  assign bus.MyID        = routerID;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_count   = fifo_count;

endmodule
